uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver directly downstream of the baud-rate generator. It consumes the 1-cycle oversampling tick (OVERSAMPLING ticks per bit) and the asynchronous serial line, and deserialises one frame: start, DATA_BITS LSB-first, optional parity, one stop. It delivers a parallel byte with a 1-cycle done strobe and error flags to the host/FIFO side.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
OVERSAMPLING, 16, ticks per bit period; must match the baud generator (even, >=8)
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only with UART_RX_PARITY_EN)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous reset, active-low
tick  in  1  oversampling strobe from the baud generator, 1 clk wide
rx  in  1  serial input, asynchronous, idle high
rx_data  out  DATA_BITS  last received word, held until next rx_done
rx_done  out  1  1-clk pulse when a frame completes (good or bad)
rx_busy  out  1  high from start-bit detection until rx_done
frame_error  out  1  stop bit sampled low; valid with rx_done, held until next rx_done
parity_error  out  1  parity mismatch; valid with rx_done, held until next rx_done

Behaviour:
- Reset (rst low, async): state IDLE, all counters 0, rx_data=0, rx_done=0, rx_busy=0, frame_error=0, parity_error=0; synchroniser flops preset to 1 (line idle).
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value rx_s (2 clk latency).
- tick_cnt (width clog2(OVERSAMPLING)) advances only on clk cycles with tick=1; no state changes between ticks except IDLE start detection and the rx_done clear.
- IDLE: on tick with rx_s=0 -> START, tick_cnt=0, rx_busy=1.
- START: on tick, when tick_cnt==OVERSAMPLING/2-1 (mid-start-bit): rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0; rx_s=1 -> false start, back to IDLE, rx_busy=0, no rx_done.
- DATA: on tick when tick_cnt==OVERSAMPLING-1: sample rx_s into shift register (LSB first, shift right), tick_cnt=0, bit_cnt++; after DATA_BITS samples -> PARITY (if enabled) else STOP.
- PARITY: one bit period later, sample and compare to XOR of data (^PARITY_ODD) -> STOP.
- STOP: one bit period later sample rx_s: rx_data<=shift reg, frame_error<=~rx_s, parity_error updated, rx_done=1 for exactly one clk, rx_busy=0, -> IDLE. Return is mid-stop-bit so back-to-back frames are caught.
- Error frames still update rx_data and pulse rx_done; no auto-resync beyond returning to IDLE (a low stop bit is detected as a new start on the next tick if line stays low).
- rx_done asserts on the clk after the sampling tick edge; never two consecutive cycles.
- Reset mid-frame aborts immediately; no partial rx_done after release.
- tick asserted continuously (degenerate) is legal: FSM then counts every clk.

Optional Feature:
UART_RX_PARITY_EN: defined -> PARITY state inserted after data bits, parity_error computed per PARITY_ODD. Undefined -> no PARITY state, frame is start+data+stop, parity_error tied 0 (port kept for interface stability).

Decomposition:
- Shared package uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP), default OVERSAMPLING=16, DATA_BITS=8, idle-line level constant.
- Sub-module uart_sync_2ff: 2-flop synchroniser with reset preset value, reused later for the TX CTS path.

Test Plan:
- Reset: hold rst=0 with rx toggling -> all outputs 0, rx_busy 0; release -> stays IDLE with rx=1.
- Clean frame 0xA5 at 9600 baud, 50 MHz (tick every 325 clk, 5200 clk/bit) -> single rx_done, rx_data=0xA5, frame_error=0, parity_error=0.
- Glitch: rx low for 3 ticks (<8) then high -> returns IDLE, no rx_done, rx_busy drops.
- Bad stop: frame 0x3C with stop bit driven 0 -> rx_done with rx_data=0x3C, frame_error=1; next clean 0x55 -> frame_error cleared.
- Back-to-back: 0x00, 0xFF, 0x81 with no idle gap -> three rx_done pulses, data in order, no errors.
- With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 -> parity_error=0; parity bit 0 -> parity_error=1; reset asserted mid-DATA -> outputs cleared, no rx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: receiver FSM encoding, default frame geometry
// and the idle level of the serial line.
package uart_pkg;

  localparam int   DEF_DATA_BITS    = 8;
  localparam int   DEF_OVERSAMPLING = 16;
  localparam logic LINE_IDLE        = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level. Both flops are
// preset to RESET_VAL so the output never shows a spurious edge at reset.
module uart_sync_2ff
  import uart_pkg::*;
#(
  parameter logic RESET_VAL = LINE_IDLE
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Metastability filter: two back-to-back flops, preset on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled deserialiser for start + DATA_BITS (LSB first)
// + optional parity + one stop bit. Bits are sampled at their centre, found
// by counting OVERSAMPLING/2 ticks into the start bit.
// Optional feature macro: UART_RX_PARITY_EN (adds the parity bit and check;
// without it parity_error is held at 0).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int OVERSAMPLING = DEF_OVERSAMPLING,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_error,
  output logic                 parity_error
);

  localparam int TW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLING / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  // Reject geometries the bit-centre logic cannot handle.
  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLING < 8 ||
      (OVERSAMPLING % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx: unsupported parameter combination");
  end

`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AFTER_DATA = ST_PARITY;
  localparam logic        PAR_ODD    = (PARITY_ODD != 0);
`else
  localparam uart_state_e AFTER_DATA = ST_STOP;
`endif

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  logic rx_s;
  logic bit_end;
  logic mid_start;

  uart_sync_2ff #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign bit_end   = tick && (tick_cnt_q == TICK_LAST);
  assign mid_start = tick && (tick_cnt_q == TICK_MID);

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: every transition except start detection waits for a bit boundary tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (tick && !rx_s) state_d = ST_START;
      ST_START:  if (mid_start) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_end && (bit_cnt_q == BIT_LAST)) state_d = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
      ST_STOP:   if (bit_end) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and output flags for each state; rx_done defaults low so it is a single-cycle pulse.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    ferr_d     = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    perr_d     = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tick && !rx_s) begin
          tick_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      ST_START: begin
        if (mid_start) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          if (rx_s) busy_d = 1'b0;  // line back high: glitch, not a start bit
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          tick_cnt_d = '0;
          shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d  = bit_cnt_q + BW'(1);
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          tick_cnt_d = '0;
          par_bad_d  = rx_s ^ (^shift_q) ^ PAR_ODD;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          tick_cnt_d = '0;
          data_d     = shift_q;
          ferr_d     = ~rx_s;
          done_d     = 1'b1;
          busy_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_d     = par_bad_q;
`endif
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign rx_data     = data_q;
  assign rx_done     = done_q;
  assign rx_busy     = busy_q;
  assign frame_error = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx (8 data bits, 16x oversampling, even parity
// when UART_RX_PARITY_EN is defined). Baud tick is scaled down to one tick
// every 4 clocks (64 clocks per bit) to keep runs short; one frame also runs
// with tick held high continuously.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int OS       = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_error;
  logic       parity_error;

  int   errors = 0;
  int   checks = 0;
  bit   tick_cont = 1'b0;
  int   div_cnt = 0;
  int   bit_clks = OS * TICK_DIV;
  int   done_total = 0;
  int   exp_total = 0;
  logic prev_done = 1'b0;
  logic [9:0] got_q[$];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLING(OS), .PARITY_ODD(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .rx_busy      (rx_busy),
    .frame_error  (frame_error),
    .parity_error (parity_error)
  );

  always #10 clk = ~clk;

  // Baud tick source: 1-clk strobe every TICK_DIV clocks, or continuous.
  always @(posedge clk) begin
    if (tick_cont) begin
      tick    <= 1'b1;
      div_cnt <= 0;
    end else if (div_cnt == TICK_DIV - 1) begin
      tick    <= 1'b1;
      div_cnt <= 0;
    end else begin
      tick    <= 1'b0;
      div_cnt <= div_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Capture every completed frame; rx_done must never stay high two cycles.
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      check_eq("done_single_cycle", {31'd0, prev_done}, 32'd0);
      got_q.push_back({parity_error, frame_error, rx_data});
      done_total++;
    end
    prev_done = rx_done;
  end

  task automatic line_bit(input logic b, input int clks);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_lvl, input int stop_clks);
    line_bit(1'b0, bit_clks);
    for (int i = 0; i < 8; i++) line_bit(d[i], bit_clks);
`ifdef UART_RX_PARITY_EN
    line_bit(par, bit_clks);
`endif
    line_bit(stop_lvl, stop_clks);
    rx = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic fe, input logic pe);
    int n;
    logic [9:0] r;
    n = 0;
    while (got_q.size() == 0 && n < 20 * bit_clks) begin
      @(negedge clk);
      n++;
    end
    exp_total++;
    check_eq({tag, "_present"}, {31'd0, got_q.size() != 0}, 32'd1);
    if (got_q.size() != 0) begin
      r = got_q.pop_front();
      check_eq({tag, "_data"}, {24'd0, r[7:0]}, {24'd0, d});
      check_eq({tag, "_ferr"}, {31'd0, r[8]}, {31'd0, fe});
      check_eq({tag, "_perr"}, {31'd0, r[9]}, {31'd0, pe});
    end
  endtask

  // Watchdog: the whole run is far shorter than this.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset held with the line toggling: everything stays cleared.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx = ~rx;
    end
    check_eq("rst_data",  {24'd0, rx_data}, 32'd0);
    check_eq("rst_done",  {31'd0, rx_done}, 32'd0);
    check_eq("rst_busy",  {31'd0, rx_busy}, 32'd0);
    check_eq("rst_ferr",  {31'd0, frame_error}, 32'd0);
    check_eq("rst_perr",  {31'd0, parity_error}, 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3 * bit_clks) @(negedge clk);
    check_eq("idle_busy", {31'd0, rx_busy}, 32'd0);
    check_eq("idle_no_done", done_total, 32'd0);

    // Clean frame.
    send_frame(8'hA5, ^8'hA5, 1'b1, bit_clks);
    expect_frame("a5", 8'hA5, 1'b0, 1'b0);
    check_eq("a5_busy_after", {31'd0, rx_busy}, 32'd0);

    // Start glitch of 3 ticks: busy rises then drops, no frame.
    rx = 1'b0;
    repeat (3 * TICK_DIV) @(negedge clk);
    check_eq("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
    rx = 1'b1;
    repeat (OS * TICK_DIV) @(negedge clk);
    check_eq("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
    check_eq("glitch_no_frame", got_q.size(), 32'd0);

    // Low stop bit (3/4 bit long so the re-detected start is rejected as a glitch).
    send_frame(8'h3C, ^8'h3C, 1'b0, 12 * TICK_DIV);
    repeat (2 * bit_clks) @(negedge clk);
    expect_frame("3c_badstop", 8'h3C, 1'b1, 1'b0);
    check_eq("badstop_no_extra", got_q.size(), 32'd0);
    check_eq("badstop_busy", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h55, ^8'h55, 1'b1, bit_clks);
    expect_frame("55_clears_ferr", 8'h55, 1'b0, 1'b0);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, ^8'h00, 1'b1, bit_clks);
    send_frame(8'hFF, ^8'hFF, 1'b1, bit_clks);
    send_frame(8'h81, ^8'h81, 1'b1, bit_clks);
    expect_frame("b2b_00", 8'h00, 1'b0, 1'b0);
    expect_frame("b2b_ff", 8'hFF, 1'b0, 1'b0);
    expect_frame("b2b_81", 8'h81, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1.
    send_frame(8'h07, 1'b1, 1'b1, bit_clks);
    expect_frame("par_ok", 8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b0, 1'b1, bit_clks);
    expect_frame("par_bad", 8'h07, 1'b0, 1'b1);
`endif

    // Degenerate continuous tick: one bit every OS clocks.
    @(negedge clk);
    tick_cont = 1'b1;
    bit_clks  = OS;
    repeat (4 * OS) @(negedge clk);
    send_frame(8'h5A, ^8'h5A, 1'b1, bit_clks);
    expect_frame("cont_tick_5a", 8'h5A, 1'b0, 1'b0);
    tick_cont = 1'b0;
    bit_clks  = OS * TICK_DIV;
    repeat (2 * bit_clks) @(negedge clk);

    // Reset in the middle of the data bits: outputs clear, no frame later.
    line_bit(1'b0, bit_clks);
    line_bit(1'b1, 2 * bit_clks + bit_clks / 2);
    check_eq("midrst_busy_before", {31'd0, rx_busy}, 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midrst_data", {24'd0, rx_data}, 32'd0);
    check_eq("midrst_busy", {31'd0, rx_busy}, 32'd0);
    check_eq("midrst_done", {31'd0, rx_done}, 32'd0);
    check_eq("midrst_ferr", {31'd0, frame_error}, 32'd0);
    rst = 1'b1;
    repeat (12 * bit_clks) @(negedge clk);
    check_eq("midrst_no_frame", got_q.size(), 32'd0);
    check_eq("midrst_busy_after", {31'd0, rx_busy}, 32'd0);

    check_eq("total_done_count", done_total, exp_total);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
